// File: rtl/motion_pkg.sv
// Shared constants and types for the motion board serial framing blocks.
// Frame header bytes, deframer states and the RX/TX frame geometry are used
// by both the RX packet assembler and the TX serializer / CRC blocks.
package motion_pkg;

    // Two-byte frame header that starts every packet.
    localparam logic [7:0] HDR0 = 8'hFF;
    localparam logic [7:0] HDR1 = 8'hFA;

    // Deframer states.
    typedef enum logic [1:0] {
        HUNT_H0,
        HUNT_H1,
        PAYLOAD
    } rx_state_t;

    // RX frame: header + 5 payload bytes + CRC-16.
    localparam int RX_PACKAGE_SIZE = 9;
    localparam int RX_STREAM_SIZE  = 8 * RX_PACKAGE_SIZE;

    // TX frame: header + 12 payload bytes + CRC-16.
    localparam int TX_PACKAGE_SIZE = 16;
    localparam int TX_STREAM_SIZE  = 8 * TX_PACKAGE_SIZE;

    // 1 ms of idle line at 50 MHz.
    localparam int DEFAULT_TIMEOUT_CYCLES = 50000;

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte idle counter. Counts cycles while enabled and not cleared, and
// raises a one-cycle expire strobe on the idle cycle that would bring the
// count to TIMEOUT_CYCLES. The strobe is combinational so the owner can
// react on the same edge; a clear on that cycle suppresses it.
module byte_timeout #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_IDLE = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    assign expire = enable && !clear && (cnt_q == LAST_IDLE);

    // Idle counter: restarts on any clear, while disabled, and after expiry.
    always_ff @(posedge clk) begin
        if (rst || clear || !enable || expire) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/packet_assembler.sv
// RX byte-stream deframer. Hunts for the FF FA header, collects a complete
// PACKAGE_SIZE-byte frame (header, payload, CRC) and presents it as one word
// with a single-cycle valid strobe for the downstream CRC checker. Partial
// frames that stall longer than TIMEOUT_CYCLES idle cycles are discarded and
// counted.
module packet_assembler
    import motion_pkg::*;
#(
    parameter int PACKAGE_SIZE   = RX_PACKAGE_SIZE,
    parameter int STREAM_SIZE    = RX_STREAM_SIZE,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic [7:0]             iByte,
    input  logic                   iByteValid,
    output logic [STREAM_SIZE-1:0] oData,
    output logic                   oDataValid,
    output logic                   oTimeout,
    output logic [7:0]             oDropCount
);

    // Holds every byte of the frame except the one currently arriving, so the
    // completed word is simply {pend_q, iByte}.
    localparam int PEND_W = STREAM_SIZE - 8;
    localparam logic [4:0] LAST_IDX = 5'(PACKAGE_SIZE - 1);
    localparam logic [PEND_W-1:0] HDR_LOAD = {{(PEND_W - 16){1'b0}}, HDR0, HDR1};

    rx_state_t         state_q;
    logic [4:0]        cnt_q;
    logic [PEND_W-1:0] pend_q;
    logic              expire;
    logic              tmo_enable;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    // Timer only matters once a frame has started (header byte seen).
    assign tmo_enable = (state_q != HUNT_H0);

    byte_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (iClk),
        .rst   (iRst),
        .clear (iByteValid),
        .enable(tmo_enable),
        .expire(expire)
    );

    // Deframer FSM with registered frame word, strobes and drop counter.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q    <= HUNT_H0;
            cnt_q      <= '0;
            pend_q     <= '0;
            oData      <= '0;
            oDataValid <= 1'b0;
            oTimeout   <= 1'b0;
            oDropCount <= '0;
        end else begin
            oDataValid <= 1'b0;
            oTimeout   <= 1'b0;
            if (iByteValid) begin
                case (state_q)
                    HUNT_H0: begin
                        if (iByte == HDR0) begin
                            state_q <= HUNT_H1;
                        end
                    end
                    HUNT_H1: begin
                        if (iByte == HDR1) begin
                            state_q <= PAYLOAD;
                            pend_q  <= HDR_LOAD;
                            cnt_q   <= 5'd2;
                        end else if (iByte != HDR0) begin
                            // A repeated FF keeps us waiting for FA.
                            state_q <= HUNT_H0;
                        end
                    end
                    PAYLOAD: begin
                        // Header values inside the frame are ordinary data.
                        if (cnt_q == LAST_IDX) begin
                            oData      <= {pend_q, iByte};
                            oDataValid <= 1'b1;
                            state_q    <= HUNT_H0;
                            cnt_q      <= '0;
                        end else begin
                            pend_q <= {pend_q[PEND_W-9:0], iByte};
                            cnt_q  <= cnt_q + 5'd1;
                        end
                    end
                    default: begin
                        state_q <= HUNT_H0;
                        cnt_q   <= '0;
                    end
                endcase
            end else if (expire) begin
                state_q    <= HUNT_H0;
                cnt_q      <= '0;
                oTimeout   <= 1'b1;
                oDropCount <= sat_inc8(oDropCount);
            end
        end
    end

endmodule

// File: tb/tb_packet_assembler.sv
// Bench for packet_assembler: directed frames plus randomized byte streams,
// checked cycle by cycle against a queue-based deframing model.
module tb_packet_assembler;

    localparam int T = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         v   = 1'b0;
    logic [7:0]   b   = 8'h00;
    logic         v16 = 1'b0;
    logic [7:0]   b16 = 8'h00;
    logic         nv16 = 1'b0;
    logic [7:0]   nb16 = 8'h00;

    logic [71:0]  d;
    logic         dv, to;
    logic [7:0]   dc;
    logic [127:0] d16;
    logic         dv16, to16;
    logic [7:0]   dc16;

    packet_assembler #(
        .PACKAGE_SIZE(9), .STREAM_SIZE(72), .TIMEOUT_CYCLES(T)
    ) dut (
        .iClk(clk), .iRst(rst), .iByte(b), .iByteValid(v),
        .oData(d), .oDataValid(dv), .oTimeout(to), .oDropCount(dc)
    );

    packet_assembler #(
        .PACKAGE_SIZE(16), .STREAM_SIZE(128), .TIMEOUT_CYCLES(T)
    ) dut16 (
        .iClk(clk), .iRst(rst), .iByte(b16), .iByteValid(v16),
        .oData(d16), .oDataValid(dv16), .oTimeout(to16), .oDropCount(dc16)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: bytes of the frame collected so far, idle cycles since
    // the last byte, and the outputs expected after the current edge.
    logic [7:0]  mq[$];
    int          midle = 0;
    logic [71:0] m_data = '0;
    bit          m_vld = 0;
    bit          m_to = 0;
    int          m_drop = 0;
    int          cyc = 0;
    int          pulses = 0;
    int          pulse_cycs[$];

    task automatic model(input bit r, input bit vv, input logic [7:0] bb);
        logic [71:0] acc;
        m_vld = 0;
        m_to  = 0;
        if (r) begin
            mq.delete();
            midle  = 0;
            m_data = '0;
            m_drop = 0;
        end else if (vv) begin
            midle = 0;
            if (mq.size() == 0) begin
                if (bb == 8'hFF) mq.push_back(bb);
            end else if (mq.size() == 1) begin
                if (bb == 8'hFA) mq.push_back(bb);
                else if (bb != 8'hFF) mq.delete();
            end else begin
                mq.push_back(bb);
                if (mq.size() == 9) begin
                    acc = '0;
                    foreach (mq[i]) acc = {acc[63:0], mq[i]};
                    m_data = acc;
                    m_vld  = 1;
                    mq.delete();
                end
            end
        end else if (mq.size() > 0) begin
            midle++;
            if (midle == T) begin
                m_to = 1;
                if (m_drop < 255) m_drop++;
                mq.delete();
                midle = 0;
            end
        end
    endtask

    task automatic step(input bit r, input bit vv, input logic [7:0] bb);
        @(negedge clk);
        rst = r; v = vv; b = bb; v16 = nv16; b16 = nb16;
        @(posedge clk);
        model(r, vv, bb);
        cyc++;
        #1;
        check_eq("data", d, m_data);
        check_eq("valid", dv, m_vld);
        check_eq("timeout", to, m_to);
        check_eq("drops", dc, m_drop);
        if (dv) begin
            pulses++;
            pulse_cycs.push_back(cyc);
        end
    endtask

    task automatic send(input logic [7:0] q[$], input int gap);
        foreach (q[i]) begin
            step(0, 1, q[i]);
            repeat (gap) step(0, 0, 8'h00);
        end
    endtask

    logic [7:0]   fr[$];
    logic [127:0] exp16;
    logic [71:0]  hold;
    int           p0;
    int           gap;
    int           act;

    initial begin
        // Reset state
        step(1, 0, 8'h00);
        step(1, 0, 8'h00);
        check_eq("rst_data", d, 72'h0);
        check_eq("rst_valid", dv, 1'b0);
        check_eq("rst_drops", dc, 8'h00);
        step(0, 0, 8'h00);

        // 16-byte frame on the wide instance
        exp16 = '0;
        for (int i = 0; i < 16; i++) begin
            nb16 = (i == 0) ? 8'hFF : (i == 1) ? 8'hFA : 8'($urandom_range(0, 255));
            nv16 = 1'b1;
            exp16 = {exp16[119:0], nb16};
            step(0, 0, 8'h00);
        end
        nv16 = 1'b0;
        check_eq("w16_valid", dv16, 1'b1);
        check_eq("w16_header", d16[127:112], 16'hFFFA);
        check_eq("w16_last", d16[7:0], exp16[7:0]);
        check_eq("w16_data", d16, exp16);
        step(0, 0, 8'h00);
        check_eq("w16_valid_off", dv16, 1'b0);
        check_eq("w16_timeout", to16, 1'b0);
        check_eq("w16_drops", dc16, 8'h00);

        // Clean frame, one byte every 4 cycles
        p0 = pulses;
        fr = '{8'hFF, 8'hFA, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00, 8'h76, 8'h7D};
        send(fr, 3);
        check_eq("clean_data", d, 72'hFFFA8080800000767D);
        check_eq("clean_pulses", pulses - p0, 1);

        // Resync through a doubled FF
        p0 = pulses;
        fr = '{8'h12, 8'hFF, 8'hFF, 8'hFA, 8'h17, 8'h17, 8'h17, 8'hE0, 8'h00, 8'h4D, 8'h8A};
        send(fr, 0);
        check_eq("resync_data", d, 72'hFFFA171717E0004D8A);
        check_eq("resync_pulses", pulses - p0, 1);

        // False header, then a frame with an embedded FF
        p0 = pulses;
        fr = '{8'hFF, 8'h00, 8'hFA, 8'h80};
        send(fr, 1);
        check_eq("false_hdr_pulses", pulses - p0, 0);
        fr = '{8'hFF, 8'hFA, 8'h1B, 8'h90, 8'h22, 8'hE0, 8'hFF, 8'h7A, 8'h11};
        send(fr, 0);
        check_eq("embedded_ff_data", d, 72'hFFFA1B9022E0FF7A11);
        check_eq("embedded_ff_pulses", pulses - p0, 1);

        // Timeout after a partial frame
        hold = d;
        fr = '{8'hFF, 8'hFA, 8'h80, 8'h80};
        send(fr, 0);
        repeat (T - 1) step(0, 0, 8'h00);
        check_eq("tmo_early", to, 1'b0);
        step(0, 0, 8'h00);
        check_eq("tmo_pulse", to, 1'b1);
        check_eq("tmo_drops", dc, 8'd1);
        check_eq("tmo_hold", d, hold);
        fr = '{8'hFF, 8'hFA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        send(fr, 2);
        check_eq("after_tmo_data", d, 72'hFFFA01020304050607);

        // Byte arriving on the timeout cycle wins
        fr = '{8'hFF, 8'hFA, 8'h80};
        send(fr, 0);
        repeat (T - 1) step(0, 0, 8'h00);
        step(0, 1, 8'h81);
        check_eq("race_no_tmo", to, 1'b0);
        fr = '{8'h82, 8'h83, 8'h84, 8'h85, 8'h86};
        send(fr, 0);
        check_eq("race_data", d, 72'hFFFA80818283848586);
        check_eq("race_drops", dc, 8'd1);

        // Back-to-back frames
        pulse_cycs.delete();
        fr = '{8'hFF, 8'hFA, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7,
               8'hFF, 8'hFA, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7};
        send(fr, 0);
        check_eq("b2b_count", pulse_cycs.size(), 2);
        if (pulse_cycs.size() == 2) check_eq("b2b_spacing", pulse_cycs[1] - pulse_cycs[0], 9);
        check_eq("b2b_data", d, 72'hFFFAB1B2B3B4B5B6B7);

        // Reset in the middle of a frame
        fr = '{8'hFF, 8'hFA, 8'h01, 8'h02, 8'h03};
        send(fr, 0);
        step(1, 0, 8'h00);
        check_eq("midrst_data", d, 72'h0);
        check_eq("midrst_drops", dc, 8'h00);
        p0 = pulses;
        fr = '{8'h04, 8'h05, 8'h06, 8'h07};
        send(fr, 0);
        check_eq("midrst_pulses", pulses - p0, 0);

        // Randomized streams: frames with jittered gaps, junk and idle runs
        for (int it = 0; it < 400; it++) begin
            act = $urandom_range(0, 9);
            if (act < 6) begin
                fr = '{8'hFF, 8'hFA};
                for (int k = 0; k < 7; k++) fr.push_back(8'($urandom_range(0, 255)));
                foreach (fr[k]) begin
                    step(0, 1, fr[k]);
                    gap = $urandom_range(0, 19);
                    if (gap == 19) gap = T - 2 + $urandom_range(0, 3);
                    else gap = gap % 3;
                    repeat (gap) step(0, 0, 8'h00);
                end
            end else if (act < 8) begin
                step(0, 1, ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255)));
            end else begin
                repeat ($urandom_range(1, 8)) step(0, 0, 8'h00);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
